demux_dist: RTL
===============

// Module: demux_dist
// PURPOSE
//  Registered 1:31 demultiplexer: inverse of the 31:1 select mux. One 2-bit symbol
//  arrives tagged with a 5-bit destination, is buffered in that lane's one-entry
//  holding register and presented on that lane with valid/ready handshaking.
//  Sits upstream of per-lane consumers. Illegal destinations are dropped and counted.
// PARAMETERS
//  NUM_LANES  31  output lanes; legal sel range 0..NUM_LANES-1 (NUM_LANES <= 2**SEL_W)
//  DATA_W     2   symbol width
//  SEL_W      5   destination select width
//  CNT_W      8   width of drop counter
// PORTS
//  clk        in   1                  single clock, rising edge
//  reset      in   1                  synchronous, active-high
//  in_valid   in   1                  input symbol valid
//  in_ready   out  1                  input accepted this cycle when in_valid&in_ready
//  in_sel     in   SEL_W              destination lane
//  in_data    in   DATA_W             symbol
//  out_valid  out  NUM_LANES          per-lane valid, bit i = lane i
//  out_ready  in   NUM_LANES          per-lane consumer ready
//  out_data   out  NUM_LANES*DATA_W   lane i at [i*DATA_W +: DATA_W]
//  drop_pulse out  1                  1-cycle pulse: illegal-sel symbol dropped
//  drop_cnt   out  CNT_W              saturating count of dropped symbols
// BEHAVIOUR
//  - Reset (sync, active-high): out_valid=0, out_data=0, drop_pulse=0, drop_cnt=0.
//    Reset mid-operation discards every buffered symbol; no lane handshake completes.
//  - Lane i full = out_valid[i]. Lane transfer when out_valid[i]&out_ready[i].
//  - Legal sel (in_sel < NUM_LANES):
//    in_ready = ~out_valid[in_sel] | out_ready[in_sel]  (combinational, from regs+ready).
//    On accept: out_data[lane] <= in_data, out_valid[lane] <= 1 next edge.
//    Latency: accept at edge N -> visible on lane at cycle N+1. Throughput 1/clk/lane.
//  - Simultaneous drain+refill on same lane: both occur; out_valid stays 1, data
//    replaced by new symbol. No bubble.
//  - Drain without refill: out_valid[i] <= 0; out_data[i] holds last value.
//  - Only the addressed lane changes on accept; all other lanes unaffected, and
//    every lane drains independently in the same cycle.
//  - Illegal sel (in_sel >= NUM_LANES, i.e. 31): in_ready=1, symbol dropped,
//    drop_pulse=1 next cycle, drop_cnt += 1, saturates at 2**CNT_W-1.
//  - in_ready is don't-care-valued but must be computed from in_sel even when
//    in_valid=0; no state changes without in_valid.
//  - out_valid[i] once set stays set, data stable, until out_ready[i] seen (AXI-style).
//  - No X propagation: out_data driven from registers only.
// STRUCTURE
//  - Shared package: DEMUX_LANES=31, DEMUX_DATA_W=2, DEMUX_SEL_W=5, ILLEGAL_SEL=5'd31.
//  - One sub-module natural: demux_lane_buf (one-entry valid/ready holding register,
//    inputs load/load_data/ready); generate NUM_LANES instances. Top holds decode,
//    in_ready mux, drop counter.
// TESTING
//  1 Reset: drive junk, reset=1 two cycles -> all out_valid=0, out_data=0, drop_cnt=0.
//  2 Routing: sel=12 data=2'b10, out_ready all 1 -> next cycle out_valid=1<<12,
//    lane12=2'b10; sel=13 data=2'b01 -> only lane13 set; sel=30 reaches lane30.
//  3 Backpressure: out_ready[5]=0, send sel=5 d=3 -> lane5 full; send sel=5 d=1 ->
//    in_ready=0, lane5 holds 3; raise out_ready[5] -> in_ready=1, lane5 becomes 1 same edge.
//  4 Independence: lane5 stalled, send sel=6 d=2 -> accepted, lane6 valid, lane5 intact.
//  5 Illegal sel: sel=31 x3 -> in_ready=1, no out_valid change, 3 drop_pulses,
//    drop_cnt=3; 260 drops -> drop_cnt=255.
//  6 Reset mid-op: lanes 0,7,30 full and stalled, assert reset -> all cleared next edge.

Source files
------------

// File: rtl/demux_dist_pkg.sv
// Shared widths, lane count, symbol payload type and select legality helper for demux_dist.
package demux_dist_pkg;

  localparam int unsigned DEMUX_LANES  = 31;
  localparam int unsigned DEMUX_DATA_W = 2;
  localparam int unsigned DEMUX_SEL_W  = 5;
  localparam int unsigned DEMUX_CNT_W  = 8;

  localparam logic [DEMUX_SEL_W-1:0] ILLEGAL_SEL = 5'd31;

  // One incoming symbol together with its destination lane
  typedef struct packed {
    logic [DEMUX_SEL_W-1:0]  sel;
    logic [DEMUX_DATA_W-1:0] data;
  } demux_sym_t;

  // A destination is legal when it names an existing lane
  function automatic logic sel_is_legal(input logic [DEMUX_SEL_W-1:0] sel);
    return 32'(sel) < DEMUX_LANES;
  endfunction

endpackage

// File: rtl/demux_dist_if.sv
// Input symbol handshake plus per-lane output handshakes of demux_dist.
interface demux_dist_if;
  import demux_dist_pkg::*;

  logic                                 in_valid;
  logic                                 in_ready;
  logic [DEMUX_SEL_W-1:0]               in_sel;
  logic [DEMUX_DATA_W-1:0]              in_data;
  logic [DEMUX_LANES-1:0]               out_valid;
  logic [DEMUX_LANES-1:0]               out_ready;
  logic [DEMUX_LANES*DEMUX_DATA_W-1:0]  out_data;

  // Producer of symbols and consumer of lanes
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The demultiplexer itself
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_lane_buf.sv
// One-entry valid/ready holding register for a single output lane.
module demux_lane_buf
  import demux_dist_pkg::*;
#(
  parameter int unsigned DATA_W = DEMUX_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              can_load
);

  // Slot is free when empty or when the consumer takes the held symbol this cycle
  assign can_load = ~valid | ready;

  // Load wins over drain so a same-cycle drain+refill keeps valid high with new data
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_dist.sv
// Registered 1:31 demultiplexer: routes each symbol to its lane buffer, drops and counts illegal selects.
module demux_dist
  import demux_dist_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  demux_dist_if.slave            bus,
  output logic                   drop_pulse,
  output logic [DEMUX_CNT_W-1:0] drop_cnt
);

  localparam int unsigned NUM_LANES = DEMUX_LANES;
  localparam int unsigned DATA_W    = DEMUX_DATA_W;
  localparam int unsigned SEL_W     = DEMUX_SEL_W;
  localparam int unsigned SEL_SPAN  = 1 << SEL_W;
  localparam int unsigned PAD       = SEL_SPAN - NUM_LANES;

  demux_sym_t              sym;
  logic                    sel_legal;
  logic                    accept;
  logic                    drop_evt;
  logic [NUM_LANES-1:0]    can_load;
  logic [NUM_LANES-1:0]    load;
  logic [SEL_SPAN-1:0]     ready_map;

  // Ready mux over every select code; codes with no lane always accept (and drop)
  always_comb begin
    sym          = '{sel: bus.in_sel, data: bus.in_data};
    sel_legal    = sel_is_legal(sym.sel);
    ready_map    = {{PAD{1'b1}}, can_load};
    bus.in_ready = ready_map[sym.sel];
    accept       = bus.in_valid & bus.in_ready;
    drop_evt     = bus.in_valid & ~sel_legal;
  end

  // One holding register per lane; only the addressed lane loads
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign load[i] = accept & (sym.sel == SEL_W'(i));

    demux_lane_buf #(.DATA_W(DATA_W)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .load_data (sym.data),
      .ready     (bus.out_ready[i]),
      .valid     (bus.out_valid[i]),
      .data      (bus.out_data[i*DATA_W +: DATA_W]),
      .can_load  (can_load[i])
    );
  end

  // Drop pulse and saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop_evt;
      if (drop_evt && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DEMUX_CNT_W'(1);
      end
    end
  end

endmodule
